core_ras_recover: RTL
=====================

Name: core_ras_recover

Overview:
Decode-stage recovery controller for the fetch-stage return address stack (RAS). It latches the fetch-stage RAS prediction (call/return flags, popped address) alongside the instruction into the IF/ID register. It then compares them with the decoded instruction class and drives the RAS recovery interface (recover_push, recover_push_addr, recover_pop). Where fetch went down a wrong sequential path, it also issues a fetch redirect, and it freezes fetch-side RAS updates while a repair is in flight.

Parameters:
RET_OFFSET, 2, word offset from the call PC to its return address (JAL plus delay slot = +8 bytes).
PC_W, 30, word-address width; fixed to match the RAS entry width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_valid  in  1  fetch presents an instruction this cycle
if_pc  in  30  word PC of fetched instruction
if_pred_call  in  1  fetch treated instruction as call (RAS pushed)
if_pred_ret  in  1  fetch treated instruction as return (RAS popped)
if_ret_addr  in  32  RAS ret_addr_out sampled at fetch; bits [31:2] are the popped entry
id_stall  in  1  downstream stall; ID register holds
id_flush  in  1  kill the instruction in ID (later-stage redirect)
dec_is_call  in  1  decoder: instruction in ID is JAL (valid when id_valid)
dec_is_ret  in  1  decoder: instruction in ID is JR (valid when id_valid)
id_valid  out  1  ID register holds a live instruction
id_pc  out  30  PC of the ID instruction
recover_push  out  1  to RAS; push recover_push_addr
recover_push_addr  out  30  to RAS
recover_pop  out  1  to RAS; pop one entry
ras_freeze  out  1  fetch must gate en_call_in/en_ret_in low
id_hold  out  1  recovery busy; upstream must not advance ID
redirect_valid  out  1  fetch redirect request
redirect_pc  out  30  redirect target (word address)
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset: id_valid=0, state=IDLE, done=0; all recovery and redirect outputs 0, id_pc=0, redirect_pc=0.
- ID load: when state==IDLE and !id_stall and !id_hold, capture if_valid, if_pc, if_pred_call, if_pred_ret, and if_ret_addr[31:2]; clear done.
- If if_pred_call and if_pred_ret are both 1, only pred_ret is latched.
- id_flush, including when asserted with id_stall: next cycle id_valid=0, state=IDLE, done=0, and any pending redirect is dropped.
- First action is combinational (Mealy), in the first cycle with id_valid && !done && state==IDLE. done is set at the following edge, so each instruction triggers exactly one first action even while stalled.
- Case table (p=popped address, pc=id_pc):
  - A: pred_ret, not call, not ret: push p; then go to REDIR with target pc+1.
  - B: pred_ret and is_call: push p; then go to SECOND, which pushes pc+RET_OFFSET.
  - C: pred_call, not call, not ret: pop; then go to REDIR with target pc+1.
  - D: pred_call and is_ret: pop; then go to SECOND, which pops again.
  - E: no prediction and is_call: push pc+RET_OFFSET.
  - F: no prediction and is_ret: pop.
  - Predictions matching the decode: no action.
- recover_push and recover_pop are never asserted in the same cycle.
- SECOND: lasts 1 cycle and drives the second op, then returns to IDLE.
- REDIR: redirect_valid=1 and redirect_pc held stable until redirect_ready is sampled high; the state returns to IDLE on that edge.
- id_hold = (state != IDLE).
- ras_freeze = (first action in progress) OR (state != IDLE).
- Arithmetic: pc+1 and pc+RET_OFFSET are modulo 2^30, wrapping at 30'h3FFFFFFF.
- rst or id_flush mid-SECOND/REDIR: abort and clear outputs the next cycle. A second op not yet issued is not issued.

Test Plan:
- pc=30'h100, pred_ret, p=30'h2A0, decode plain ALU -> cycle T: recover_push=1, addr=30'h2A0. T+1: redirect_valid=1, redirect_pc=30'h101, held 3 cycles with ready=0, then drops after ready.
- pc=30'h200, pred_ret, p=30'h55, decode JAL -> T: push 30'h55; T+1: push 30'h202; id_hold=1 at T+1 only; no redirect.
- pc=30'h300, pred_call, decode JR -> recover_pop on T and T+1; never asserted together with recover_push.
- No prediction, pc=30'h3FFFFFFF, decode JAL -> push addr 30'h1 (wrap). Hold id_stall=1 for 4 cycles -> exactly one push.
- Case A with id_flush at T+1 -> redirect_valid=0 at T+2, state IDLE, id_valid=0.
- Matching prediction (pred_call and JAL) -> no recover or redirect activity, ras_freeze=0. rst mid-REDIR -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/core_ras_recover.sv
// ---------------------------------------------------------------------------
// core_ras_recover
//
// Decode-stage recovery controller for the fetch-stage return address stack.
// The IF/ID register captures the fetched instruction together with what the
// fetch stage did to the RAS (pushed as a call, popped as a return, and the
// popped address). Once the instruction is decoded, the prediction is compared
// against the real instruction class and the RAS is repaired:
//
//   pred_ret, plain instr : push popped addr back, redirect fetch to pc+1
//   pred_ret, JAL         : push popped addr back, then push pc+RET_OFFSET
//   pred_call, plain instr: pop the bogus entry, redirect fetch to pc+1
//   pred_call, JR         : pop the bogus entry, then pop for the real return
//   no pred, JAL          : push pc+RET_OFFSET
//   no pred, JR           : pop
//   prediction matches    : nothing
//
// The first repair op is combinational in the cycle the instruction is
// first seen in ID. The second op (SECOND) or the redirect (REDIR) follow
// from the FSM. While a repair is in flight, fetch-side RAS updates are frozen
// and ID is held.
//
// Redirect handshake: redirect_valid is raised in REDIR with redirect_pc held
// stable; the transfer completes on a clock edge where redirect_valid and
// redirect_ready are both high. Only id_flush or rst may withdraw a pending
// redirect before it is accepted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_valid/if_pc      fetched instruction and its word PC
//   if_pred_call/ret    RAS action fetch took for that instruction
//   if_ret_addr         RAS top sampled at fetch ([31:2] = popped entry)
//   id_stall, id_flush  downstream hold / kill of the ID instruction
//   dec_is_call/ret     decoder class of the ID instruction
//   id_valid, id_pc     ID register contents
//   recover_push(_addr) RAS push repair
//   recover_pop         RAS pop repair
//   ras_freeze          fetch must not update the RAS this cycle
//   id_hold             recovery busy; ID must not advance
//   redirect_valid/pc   fetch redirect request, word target
//   redirect_ready      fetch accepts the redirect
//   dbg_state           current FSM state (0 IDLE, 1 SECOND, 2 REDIR)
// ---------------------------------------------------------------------------
module core_ras_recover #(
    parameter int RET_OFFSET = 2,
    parameter int PC_W       = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [PC_W-1:0] if_pc,
    input  logic            if_pred_call,
    input  logic            if_pred_ret,
    input  logic [31:0]     if_ret_addr,
    input  logic            id_stall,
    input  logic            id_flush,
    input  logic            dec_is_call,
    input  logic            dec_is_ret,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic            recover_push,
    output logic [PC_W-1:0] recover_push_addr,
    output logic            recover_pop,
    output logic            ras_freeze,
    output logic            id_hold,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SECOND = 2'd1,
        S_REDIR  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // IF/ID register contents beyond id_valid/id_pc.
    logic            id_pred_call_q;
    logic            id_pred_ret_q;
    logic [PC_W-1:0] id_pop_addr_q;
    logic            done_q;

    // The ID register may reload in the same edge that starts SECOND/REDIR,
    // so the follow-up operation and redirect target are captured here
    // rather than recomputed from id_pc later.
    logic            second_push_q, second_push_d;
    logic [PC_W-1:0] second_addr_q, second_addr_d;
    logic [PC_W-1:0] redir_pc_q,    redir_pc_d;

    logic            load_en;
    logic            first_cond;
    logic            first_act;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_plus_ret;

    // Low two bits of the sampled RAS output are byte offsets; only the word
    // address is stored.
    logic unused_ret_lsbs;
    assign unused_ret_lsbs = ^if_ret_addr[1:0];

    // Modulo-2^PC_W arithmetic: the adders simply drop the carry.
    assign pc_plus1    = id_pc + PC_W'(1);
    assign pc_plus_ret = id_pc + PC_W'(RET_OFFSET);

    assign id_hold    = (state_q != S_IDLE);
    assign load_en    = !id_stall && !id_hold;
    // The first look at an instruction in ID; done_q makes it one-shot even
    // while the stage is stalled.
    assign first_cond = id_valid && !done_q && (state_q == S_IDLE);
    assign ras_freeze = first_act || (state_q != S_IDLE);
    assign dbg_state  = state_q;

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        second_push_d     = second_push_q;
        second_addr_d     = second_addr_q;
        redir_pc_d        = redir_pc_q;
        recover_push      = 1'b0;
        recover_push_addr = '0;
        recover_pop       = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        first_act         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (first_cond) begin
                    if (id_pred_ret_q) begin
                        // Fetch popped: restore the popped entry first.
                        if (dec_is_call) begin
                            first_act         = 1'b1;
                            recover_push      = 1'b1;
                            recover_push_addr = id_pop_addr_q;
                            second_push_d     = 1'b1;
                            second_addr_d     = pc_plus_ret;
                            state_d           = S_SECOND;
                        end else if (!dec_is_ret) begin
                            first_act         = 1'b1;
                            recover_push      = 1'b1;
                            recover_push_addr = id_pop_addr_q;
                            redir_pc_d        = pc_plus1;
                            state_d           = S_REDIR;
                        end
                    end else if (id_pred_call_q) begin
                        // Fetch pushed: discard the bogus entry first.
                        if (dec_is_ret) begin
                            first_act     = 1'b1;
                            recover_pop   = 1'b1;
                            second_push_d = 1'b0;
                            state_d       = S_SECOND;
                        end else if (!dec_is_call) begin
                            first_act   = 1'b1;
                            recover_pop = 1'b1;
                            redir_pc_d  = pc_plus1;
                            state_d     = S_REDIR;
                        end
                    end else begin
                        // Fetch missed the call/return entirely.
                        if (dec_is_call) begin
                            first_act         = 1'b1;
                            recover_push      = 1'b1;
                            recover_push_addr = pc_plus_ret;
                        end else if (dec_is_ret) begin
                            first_act   = 1'b1;
                            recover_pop = 1'b1;
                        end
                    end
                end
            end
            S_SECOND: begin
                if (second_push_q) begin
                    recover_push      = 1'b1;
                    recover_push_addr = second_addr_q;
                end else begin
                    recover_pop = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_pc_q;
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A kill from a later stage abandons any repair still in flight.
        if (id_flush) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State and IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            second_push_q  <= 1'b0;
            second_addr_q  <= '0;
            redir_pc_q     <= '0;
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_pred_call_q <= 1'b0;
            id_pred_ret_q  <= 1'b0;
            id_pop_addr_q  <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            second_push_q <= second_push_d;
            second_addr_q <= second_addr_d;
            redir_pc_q    <= redir_pc_d;

            if (id_flush) begin
                id_valid <= 1'b0;
                done_q   <= 1'b0;
            end else if (load_en) begin
                id_valid       <= if_valid;
                id_pc          <= if_pc;
                // A simultaneous call+return prediction is recorded as a
                // return only: that is the RAS action fetch performed last.
                id_pred_call_q <= if_pred_call && !if_pred_ret;
                id_pred_ret_q  <= if_pred_ret;
                id_pop_addr_q  <= if_ret_addr[31:2];
                done_q         <= 1'b0;
            end else if (first_cond) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule
